// File: rtl/det_sched.sv
// Round-robin front end that time-shares one serial Moore pattern detector.
// Each job: clear detector, shift a word MSB-first, drain the flag, report hit count.
module det_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned DRAIN = 2,
    parameter int unsigned CNT_W = 4,
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*W-1:0]   data_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic                busy_o,
    output logic                det_rst_o,
    output logic                det_din_o,
    input  logic                det_flag_i,
    output logic                done_o,
    output logic [ID_W-1:0]     done_id_o,
    output logic                hit_o,
    output logic [CNT_W-1:0]    hit_cnt_o
);

    localparam int unsigned MaxLen = (W > DRAIN) ? W : DRAIN;
    localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    typedef enum logic [2:0] {StIdle, StClear, StShift, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [W-1:0]      word_q, word_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              det_rst_q, det_rst_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic              hit_q, hit_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

    logic [W-1:0]      words [NREQ];
    logic              found;
    logic [ID_W-1:0]   sel_id;
    logic [W-1:0]      sel_word;
    logic [CNT_W-1:0]  acc_nxt;

    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            words[i] = data_i[i*W +: W];
        end
    end

    // First requester at or after the pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        sel_id   = '0;
        sel_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_i[rot_idx(ptr_q, i)]) begin
                found    = 1'b1;
                sel_id   = rot_idx(ptr_q, i);
                sel_word = words[rot_idx(ptr_q, i)];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
            word_q    <= '0;
            acc_q     <= '0;
            gnt_q     <= '0;
            det_rst_q <= 1'b1;
            done_id_q <= '0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            word_q    <= word_d;
            acc_q     <= acc_d;
            gnt_q     <= gnt_d;
            det_rst_q <= det_rst_d;
            done_id_q <= done_id_d;
            hit_q     <= hit_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) state_d = StClear;
            end
            StClear: begin
                state_d = StShift;
                cnt_d   = '0;
            end
            StShift: begin
                if (cnt_q == CntW'(W - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == CntW'(DRAIN - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        gnt_d     = '0;
        ptr_d     = ptr_q;
        id_d      = id_q;
        word_d    = word_q;
        acc_d     = acc_q;
        done_id_d = done_id_q;
        hit_d     = hit_q;
        hit_cnt_d = hit_cnt_q;
        acc_nxt   = acc_q;
        if (det_flag_i && (acc_q != {CNT_W{1'b1}})) acc_nxt = acc_q + CNT_W'(1);

        if (state_q == StIdle && found) begin
            gnt_d  = NREQ'(1) << sel_id;
            ptr_d  = (sel_id == ID_W'(NREQ - 1)) ? '0 : sel_id + ID_W'(1);
            id_d   = sel_id;
            word_d = sel_word;
        end
        if (state_q == StClear) acc_d = '0;
        if (state_q == StShift) begin
            word_d = {word_q[W-2:0], 1'b0};
            acc_d  = acc_nxt;
        end
        // Results commit on the edge entering DONE, including the last drain flag.
        if (state_q == StDrain) begin
            acc_d = acc_nxt;
            if (state_d == StDone) begin
                done_id_d = id_q;
                hit_d     = |acc_nxt;
                hit_cnt_d = acc_nxt;
            end
        end
        det_rst_d = (state_d == StClear);
    end

    always_comb begin
        busy_o    = (state_q != StIdle);
        done_o    = (state_q == StDone);
        det_din_o = (state_q == StShift) ? word_q[W-1] : 1'b1;
    end

    assign gnt_o     = gnt_q;
    assign det_rst_o = det_rst_q;
    assign done_id_o = done_id_q;
    assign hit_o     = hit_q;
    assign hit_cnt_o = hit_cnt_q;

endmodule
